// File: rtl/transpose_pingpong_buf_if.sv
// rtl/transpose_pingpong_buf_if.sv - row-in / column-out handshake bundle for the ping-pong transposer
interface transpose_pingpong_buf_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int BITS = 64
) ();
  localparam int IW = (COLS > 1) ? $clog2(COLS) : 1;

  logic                   in_valid;
  logic                   in_ready;
  logic                   in_mode;
  logic signed [BITS-1:0] in_row [0:COLS-1];

  logic                   out_valid;
  logic                   out_ready;
  logic                   out_last;
  logic        [IW-1:0]   out_idx;
  logic signed [BITS-1:0] out_col [0:ROWS-1];

  modport master (
    output in_valid, in_mode, in_row, out_ready,
    input  in_ready, out_valid, out_last, out_idx, out_col
  );

  modport slave (
    input  in_valid, in_mode, in_row, out_ready,
    output in_ready, out_valid, out_last, out_idx, out_col
  );
endinterface

// File: rtl/transpose_pingpong_buf.sv
// rtl/transpose_pingpong_buf.sv - double-buffered matrix transposer, rows in, columns out
module transpose_pingpong_buf #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int BITS = 64
) (
  input logic                     clk,
  input logic                     rst,
  transpose_pingpong_buf_if.slave bus
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  logic signed [BITS-1:0] mem [0:1][0:ROWS-1][0:COLS-1];

  logic          wb, rb;
  logic [RW-1:0] wr_row;
  logic [CW-1:0] rd_cnt;
  logic [1:0]    full, mode;

  logic          wb_n, rb_n;
  logic [RW-1:0] wr_row_n;
  logic [CW-1:0] rd_cnt_n;
  logic [1:0]    full_n, mode_n;

  logic          in_ready, out_valid;
  logic          wr_fire, rd_fire, wr_done, rd_done;
  logic [CW-1:0] col;

  assign in_ready  = !rst && !full[wb];
  assign out_valid = full[rb];
  assign wr_fire   = bus.in_valid && in_ready;
  assign rd_fire   = out_valid && bus.out_ready;
  assign wr_done   = (wr_row == ROW_LAST);
  assign rd_done   = (rd_cnt == COL_LAST);

  // Descending mode walks the columns from the far end of the latched bank.
  assign col = mode[rb] ? (COL_LAST - rd_cnt) : rd_cnt;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_idx   = col;
  assign bus.out_last  = rd_done;

  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      bus.out_col[r] = mem[rb][r][col];
    end
  end

  // A simultaneous write and read always address opposite banks, so the
  // set of full[wb] and the clear of full[rb] never collide.
  always_comb begin
    wb_n     = wb;
    rb_n     = rb;
    wr_row_n = wr_row;
    rd_cnt_n = rd_cnt;
    full_n   = full;
    mode_n   = mode;
    if (wr_fire) begin
      if (wr_row == '0) begin
        mode_n[wb] = bus.in_mode;
      end
      if (wr_done) begin
        wr_row_n   = '0;
        full_n[wb] = 1'b1;
        wb_n       = !wb;
      end else begin
        wr_row_n = wr_row + 1'b1;
      end
    end
    if (rd_fire) begin
      if (rd_done) begin
        rd_cnt_n   = '0;
        full_n[rb] = 1'b0;
        rb_n       = !rb;
      end else begin
        rd_cnt_n = rd_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb     <= 1'b0;
      rb     <= 1'b0;
      wr_row <= '0;
      rd_cnt <= '0;
      full   <= 2'b00;
      mode   <= 2'b00;
    end else begin
      wb     <= wb_n;
      rb     <= rb_n;
      wr_row <= wr_row_n;
      rd_cnt <= rd_cnt_n;
      full   <= full_n;
      mode   <= mode_n;
    end
  end

  // Bank contents carry no reset; the full flags alone decide what is visible.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int c = 0; c < COLS; c++) begin
        mem[wb][wr_row][c] <= bus.in_row[c];
      end
    end
  end
endmodule

// File: tb/tb_transpose_pingpong_buf.sv
// tb/tb_transpose_pingpong_buf.sv - directed checks of the ping-pong transposer
module tb_transpose_pingpong_buf;
  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  int   both  = 0;
  bit   mon_en = 1'b0;
  logic irl;

  always #5 clk = !clk;

  transpose_pingpong_buf_if #(.ROWS(4), .COLS(4), .BITS(8)) a_if ();
  transpose_pingpong_buf_if #(.ROWS(2), .COLS(3), .BITS(8)) b_if ();

  transpose_pingpong_buf #(.ROWS(4), .COLS(4), .BITS(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  transpose_pingpong_buf #(.ROWS(2), .COLS(3), .BITS(8)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [7:0] d(input int m, input int r, input int c);
    return 8'(40 * m + 10 * r + c);
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en && a_if.in_valid && a_if.in_ready && a_if.out_valid && a_if.out_ready)
      both++;
  end

  task automatic wr_matrix(input int m, input logic md, input int nr, input bit chk);
    for (int r = 0; r < nr; r++) begin
      int n;
      n = 0;
      a_if.in_valid = 1'b1;
      a_if.in_mode  = (r == 0) ? md : !md;
      for (int c = 0; c < 4; c++) a_if.in_row[c] = d(m, r, c);
      @(negedge clk);
      if (chk) check("early_out_valid", a_if.out_valid, 0);
      while (!a_if.in_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) check("wr_timeout", a_if.in_ready, 1);
      sync();
    end
    a_if.in_valid = 1'b0;
  endtask

  task automatic rd_matrix(input int m, input logic md, input int nb, output logic ir_last);
    ir_last = 1'b0;
    for (int k = 0; k < nb; k++) begin
      int n;
      int idx;
      n = 0;
      a_if.out_ready = 1'b1;
      @(negedge clk);
      while (!a_if.out_valid && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("rd_valid", a_if.out_valid, 1);
      idx = md ? 3 - k : k;
      check("rd_idx", a_if.out_idx, idx);
      check("rd_last", a_if.out_last, k == 3);
      for (int r = 0; r < 4; r++) check("rd_data", a_if.out_col[r], d(m, r, idx));
      if (k == 3) ir_last = a_if.in_ready;
      sync();
    end
    a_if.out_ready = 1'b0;
  endtask

  task automatic b_wr_row(input int x0, input int x1, input int x2, input logic md);
    int n;
    n = 0;
    b_if.in_valid  = 1'b1;
    b_if.in_mode   = md;
    b_if.in_row[0] = 8'(x0);
    b_if.in_row[1] = 8'(x1);
    b_if.in_row[2] = 8'(x2);
    @(negedge clk);
    while (!b_if.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("b_wr_timeout", b_if.in_ready, 1);
    sync();
    b_if.in_valid = 1'b0;
  endtask

  task automatic b_rd(input logic md);
    int e0 [0:2];
    int e1 [0:2];
    e0 = '{-1, -2, -3};
    e1 = '{4, 5, -6};
    for (int k = 0; k < 3; k++) begin
      int idx;
      idx = md ? 2 - k : k;
      b_if.out_ready = 1'b1;
      @(negedge clk);
      check("b_valid", b_if.out_valid, 1);
      check("b_idx", b_if.out_idx, idx);
      check("b_last", b_if.out_last, k == 2);
      check("b_row0", b_if.out_col[0], e0[idx]);
      check("b_row1", b_if.out_col[1], e1[idx]);
      sync();
    end
    b_if.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_if.in_valid = 1'b0; a_if.in_mode = 1'b0; a_if.out_ready = 1'b0;
    b_if.in_valid = 1'b0; b_if.in_mode = 1'b0; b_if.out_ready = 1'b0;
    for (int c = 0; c < 4; c++) a_if.in_row[c] = '0;
    for (int c = 0; c < 3; c++) b_if.in_row[c] = '0;

    repeat (2) @(negedge clk);
    check("rst_a_in_ready", a_if.in_ready, 0);
    check("rst_a_out_valid", a_if.out_valid, 0);
    check("rst_b_in_ready", b_if.in_ready, 0);
    check("rst_b_out_valid", b_if.out_valid, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", a_if.in_ready, 1);
    sync();

    // 1: single ascending transpose, first column the cycle after the last row
    wr_matrix(0, 1'b0, 4, 1'b1);
    @(negedge clk);
    check("t1_valid_after_row3", a_if.out_valid, 1);
    sync();
    rd_matrix(0, 1'b0, 4, irl);
    @(negedge clk);
    check("t1_empty", a_if.out_valid, 0);
    sync();

    // 2: descending order latched from row 0 only
    wr_matrix(1, 1'b1, 4, 1'b0);
    rd_matrix(1, 1'b1, 4, irl);

    // 3: backpressure, both banks full, held output, in_ready one cycle after drain
    wr_matrix(0, 1'b0, 4, 1'b0);
    wr_matrix(1, 1'b1, 4, 1'b0);
    a_if.in_valid = 1'b1;
    a_if.in_mode  = 1'b1;
    for (int c = 0; c < 4; c++) a_if.in_row[c] = d(2, 0, c);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_in_ready_blocked", a_if.in_ready, 0);
      check("t3_hold_valid", a_if.out_valid, 1);
      check("t3_hold_idx", a_if.out_idx, 0);
      for (int r = 0; r < 4; r++) check("t3_hold_data", a_if.out_col[r], d(0, r, 0));
      sync();
    end
    a_if.in_valid = 1'b0;
    rd_matrix(0, 1'b0, 4, irl);
    check("t3_in_ready_same_cycle", irl, 0);
    @(negedge clk);
    check("t3_in_ready_next", a_if.in_ready, 1);
    sync();
    fork
      wr_matrix(2, 1'b1, 4, 1'b0);
      begin
        rd_matrix(1, 1'b1, 4, irl);
        rd_matrix(2, 1'b1, 4, irl);
      end
    join

    // 4: continuous overlap over three matrices with alternating modes
    both   = 0;
    mon_en = 1'b1;
    fork
      begin
        wr_matrix(0, 1'b0, 4, 1'b0);
        wr_matrix(1, 1'b1, 4, 1'b0);
        wr_matrix(2, 1'b0, 4, 1'b0);
      end
      begin
        rd_matrix(0, 1'b0, 4, irl);
        rd_matrix(1, 1'b1, 4, irl);
        rd_matrix(2, 1'b0, 4, irl);
      end
    join
    mon_en = 1'b0;
    check("t4_overlap_cycles", both, 8);

    // 5: non-square 2x3 with negative elements, both orders
    b_wr_row(-1, -2, -3, 1'b0);
    b_wr_row(4, 5, -6, 1'b1);
    b_rd(1'b0);
    b_wr_row(-1, -2, -3, 1'b1);
    b_wr_row(4, 5, -6, 1'b0);
    b_rd(1'b1);
    @(negedge clk);
    check("t5_empty", b_if.out_valid, 0);
    sync();

    // 6: reset with one bank half-read and the other half-written
    wr_matrix(0, 1'b0, 4, 1'b0);
    rd_matrix(0, 1'b0, 2, irl);
    wr_matrix(1, 1'b0, 2, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_out_valid", a_if.out_valid, 0);
    check("t6_rst_in_ready", a_if.in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_post_out_valid", a_if.out_valid, 0);
    check("t6_post_in_ready", a_if.in_ready, 1);
    sync();
    wr_matrix(2, 1'b0, 4, 1'b1);
    rd_matrix(2, 1'b0, 4, irl);
    @(negedge clk);
    check("t6_no_stale", a_if.out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/transpose_pingpong_buf.md
Name: transpose_pingpong_buf

Overview:
- Double-buffered (ping-pong) matrix transposer for the systolic datapath.
- Accepts a ROWS x COLS matrix one full row per beat.
- Emits it one full column per beat, in ascending or descending column order, selected per matrix.
- One bank fills while the other drains; both sides use valid/ready handshakes.

Parameters:
- ROWS, 8, rows per matrix; also the number of elements in each output column.
- COLS, 8, columns per matrix; also the number of elements in each input row.
- BITS, 64, signed element width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_row/in_mode valid.
- in_ready  output  1  buffer can accept a row this cycle.
- in_row  input  signed [BITS-1:0] x [0:COLS-1]  one matrix row; element c is column c.
- in_mode  input  1  sampled with row 0 only. 0 = emit columns 0..COLS-1; 1 = emit columns COLS-1..0.
- out_valid  output  1  out_col valid.
- out_ready  input  1  consumer accepts out_col this cycle.
- out_col  output  signed [BITS-1:0] x [0:ROWS-1]  one matrix column; element r is row r.
- out_idx  output  $clog2(COLS) (min 1)  source column index of out_col.
- out_last  output  1  final column of the current matrix.

Behaviour:
- Storage:
  - Two banks, B0 and B1, each ROWS x COLS x BITS.
  - Per-bank state: full flag and latched mode bit.
  - Write side: wb bank select, wr_row counter.
  - Read side: rb bank select, rd_cnt counter.
- Reset (async, rst=1):
  - wb=rb=0, wr_row=rd_cnt=0, both full flags=0, both mode bits=0.
  - out_valid=0, in_ready=0 while rst is high.
  - Bank contents are not reset; out_col/out_idx/out_last are don't-care while out_valid=0.
  - Reset mid-matrix discards all partial and full matrices. No output beat follows reset until a complete new matrix is written.
- Write side:
  - in_ready = !rst && !full[wb].
  - A write beat occurs when in_valid && in_ready: bank[wb][wr_row][c] <= in_row[c] for all c.
  - When wr_row==0, mode[wb] <= in_mode.
  - wr_row increments on each beat. On the beat with wr_row==ROWS-1: wr_row <= 0, full[wb] <= 1, wb toggles.
  - No beat occurs when in_valid=0; no state changes.
- Read side:
  - out_valid = full[rb].
  - Column select: col = rd_cnt if mode[rb]==0, else COLS-1-rd_cnt.
  - out_col[r] = bank[rb][r][col]; out_idx = col; out_last = (rd_cnt==COLS-1).
  - Outputs are combinational from registered state, so they are stable while out_valid && !out_ready.
  - A read beat occurs when out_valid && out_ready: rd_cnt increments.
  - On the read beat with out_last: rd_cnt <= 0, full[rb] <= 0, rb toggles.
- Latency and throughput:
  - The first column is valid in the cycle after the last row's write beat.
  - There is no combinational in->out path.
  - A matrix needs ROWS write beats and COLS read beats.
  - With both banks cycling, sustained throughput is min(ROWS,COLS)/max(ROWS,COLS) of full rate on the slower side, with no bubbles inserted by the block.
- Boundary conditions:
  - Both banks full: in_ready=0 until a read beat with out_last clears full[wb]. in_ready rises the following cycle; freed space is not passed through in the same cycle.
  - Write and read beats in the same cycle always target different banks and proceed independently.
  - The last-row write of bank X and the last-column read of bank Y in the same cycle both take effect: full[X]=1, full[Y]=0, wb and rb both toggle.
  - Both banks empty: out_valid=0; out_ready is ignored.
  - Mode is per matrix. in_mode on rows 1..ROWS-1 is ignored. A mode change between matrices never affects a matrix already being read.
  - ROWS!=COLS is supported; counters wrap at ROWS and COLS respectively.
  - ROWS=1 or COLS=1 is legal: a single beat completes the fill or the drain.

Test Plan:
1. Single transpose, ROWS=COLS=4, BITS=8. Rows r with element c = 10r+c, mode 0, out_ready=1 → 4 beats with out_idx 0..3, out_col[r]=10r+idx, out_last on beat 4, out_valid first high the cycle after row 3.
2. Descending mode, same data with in_mode=1 on row 0 (in_mode=0 on rows 1-3) → out_idx 3,2,1,0, out_col[r]=10r+out_idx.
3. Backpressure: out_ready=0 → three matrices offered; two accepted, in_ready=0 after the 8th row beat. out_col is held stable. Raise out_ready → after the 4th read beat, in_ready=1 the next cycle and the third matrix is accepted.
4. Ping-pong overlap: continuous in_valid/out_ready=1 over 3 matrices. Every cycle after the first fill has both a write beat and a read beat; output order and data are exact, and matrix 2's mode is independent of matrix 1's.
5. Non-square, ROWS=2, COLS=3, with negative values (-1,-2,-3 / 4,5,-6) → 3 beats: (-1,4), (-2,5), (-3,-6).
6. Reset mid-operation: assert rst after 2 rows of matrix 1, with matrix 0 full and half-read → out_valid=0 and in_ready=0 during reset. After release a new full matrix is output alone with rd_cnt starting at 0; no stale rows or columns appear.
